pixel_stream_tx: RTL and testbench

// Raster pixel-stream transmitter: the source end of the 8-bit data/enable stream consumed by the 3x3 window filters.
// On a start pulse, reads one IMG_W x IMG_H frame from a synchronous-read frame-buffer port in raster order.

---
 rtl/pixel_stream_tx_if.sv | 23 ++
 rtl/pixel_stream_tx.sv | 165 ++++++++++++++++
 tb/tb_pixel_stream_tx.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pixel_stream_tx_if.sv
// Frame-buffer read port plus outgoing 8-bit pixel stream of pixel_stream_tx.
// master = transmitter side, slave = frame buffer / downstream consumer side.
interface pixel_stream_tx_if #(
  parameter int ADDR_W = 19
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_data;
  logic [7:0]        data_out;
  logic              data_out_en;
  logic              sof;
  logic              eol;

  modport master (
    output mem_rd, mem_addr, data_out, data_out_en, sof, eol,
    input  mem_data
  );

  modport slave (
    input  mem_rd, mem_addr, data_out, data_out_en, sof, eol,
    output mem_data
  );
endinterface

// File: rtl/pixel_stream_tx.sv
// Raster pixel-stream transmitter: reads an IMG_W x IMG_H frame and emits line bursts with H/V blanking.
// Define PIXEL_TX_TEST_PATTERN_EN to replace frame-buffer reads with an (x+y) ramp pattern.
module pixel_stream_tx #(
  parameter int IMG_W  = 640,
  parameter int IMG_H  = 480,
  parameter int HBLANK = 16,
  parameter int VBLANK = 64,
  parameter int ADDR_W = 19,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               frame_done,
  pixel_stream_tx_if.master  bus
);
  localparam int X_W    = $clog2(IMG_W);
  localparam int Y_W    = $clog2(IMG_H);
  localparam int BL_MAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
  localparam int B_W    = $clog2(BL_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_HBLANK, S_VBLANK} state_t;

  state_t            state;
  logic [X_W-1:0]    x;
  logic [Y_W-1:0]    y;
  logic [B_W-1:0]    bcnt;
  logic              rd_int;
  logic [ADDR_W-1:0] addr;
  logic [RD_LAT-1:0] rd_pipe, sof_pipe, eol_pipe;
  logic              last_x, last_y, sof_tag, eol_tag;
  logic [7:0]        pix_src;

  assign last_x  = (x == X_W'(IMG_W - 1));
  assign last_y  = (y == Y_W'(IMG_H - 1));
  assign sof_tag = rd_int && (x == '0) && (y == '0);
  assign eol_tag = rd_int && last_x;
  assign bus.mem_addr = addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      x          <= '0;
      y          <= '0;
      bcnt       <= '0;
      rd_int     <= 1'b0;
      addr       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_ACTIVE;
            busy   <= 1'b1;
            rd_int <= 1'b1;
            addr   <= '0;
            x      <= '0;
            y      <= '0;
          end
        end
        S_ACTIVE: begin
          if (!last_x) begin
            x    <= x + 1'b1;
            addr <= addr + 1'b1;
          end else if (!last_y) begin
            if (HBLANK == 0) begin
              x    <= '0;
              y    <= y + 1'b1;
              addr <= addr + 1'b1;
            end else begin
              state  <= S_HBLANK;
              rd_int <= 1'b0;
              bcnt   <= '0;
            end
          end else begin
            state      <= S_VBLANK;
            rd_int     <= 1'b0;
            bcnt       <= '0;
            frame_done <= (VBLANK == 1);
          end
        end
        S_HBLANK: begin
          if (bcnt == B_W'(HBLANK - 1)) begin
            state  <= S_ACTIVE;
            rd_int <= 1'b1;
            addr   <= addr + 1'b1;
            x      <= '0;
            y      <= y + 1'b1;
          end else begin
            bcnt <= bcnt + 1'b1;
          end
        end
        S_VBLANK: begin
          if (bcnt == B_W'(VBLANK - 1)) begin
            frame_done <= 1'b0;
            // The frame_done cycle doubles as the IDLE sample point so a held start chains frames with no gap.
            if (start) begin
              state  <= S_ACTIVE;
              rd_int <= 1'b1;
              addr   <= '0;
              x      <= '0;
              y      <= '0;
            end else begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end
          end else begin
            bcnt       <= bcnt + 1'b1;
            frame_done <= (bcnt == B_W'(VBLANK - 2));
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef PIXEL_TX_TEST_PATTERN_EN
  logic [7:0] pat_pipe [RD_LAT];
  logic       unused_mem_data;

  assign bus.mem_rd      = 1'b0;
  assign unused_mem_data = ^bus.mem_data;
  assign pix_src         = pat_pipe[RD_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < RD_LAT; i++) pat_pipe[i] <= '0;
    end else begin
      pat_pipe[0] <= 8'(x) + 8'(y);
      for (int unsigned i = 1; i < RD_LAT; i++) pat_pipe[i] <= pat_pipe[i-1];
    end
  end
`else
  assign bus.mem_rd = rd_int;
  assign pix_src    = bus.mem_data;
`endif

  // Tags travel alongside the read so they line up with returned data; data is then registered once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe         <= '0;
      sof_pipe        <= '0;
      eol_pipe        <= '0;
      bus.data_out_en <= 1'b0;
      bus.sof         <= 1'b0;
      bus.eol         <= 1'b0;
      bus.data_out    <= '0;
    end else begin
      rd_pipe[0]  <= rd_int;
      sof_pipe[0] <= sof_tag;
      eol_pipe[0] <= eol_tag;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        rd_pipe[i]  <= rd_pipe[i-1];
        sof_pipe[i] <= sof_pipe[i-1];
        eol_pipe[i] <= eol_pipe[i-1];
      end
      bus.data_out_en <= rd_pipe[RD_LAT-1];
      bus.sof         <= sof_pipe[RD_LAT-1];
      bus.eol         <= eol_pipe[RD_LAT-1];
      if (rd_pipe[RD_LAT-1]) bus.data_out <= pix_src;
    end
  end
endmodule

// File: tb/tb_pixel_stream_tx.sv
// Bench for pixel_stream_tx: random frame-buffer contents and start timing vs. an arithmetic raster model.
// Instance a uses HBLANK=2, instance b HBLANK=0.
`timescale 1ns/1ps
module tb_pixel_stream_tx;
  localparam int W = 4, H = 3, HB = 2, VB = 3, LAT = 1, AW = 8, NPIX = W * H;
`ifdef PIXEL_TX_TEST_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  typedef logic [41:0] pix_t;   // {cycle, data, sof, eol}
  typedef logic [39:0] rd_t;    // {cycle, addr}

  logic clk = 1'b0, rst_n = 1'b0, start_a = 1'b0, start_b = 1'b0;
  logic busy_a, busy_b, fd_a, fd_b;
  int   checks = 0, errors = 0, cyc = 0;
  int   stray_a = 0, stray_b = 0;
  logic [7:0] mem [256];
  logic busy_h [0:4095];
  pix_t pq_a[$], pq_b[$];
  rd_t  rq_a[$], rq_b[$];
  int   fq_a[$], fq_b[$];

  pixel_stream_tx_if #(.ADDR_W(AW)) ia ();
  pixel_stream_tx_if #(.ADDR_W(AW)) ib ();

  pixel_stream_tx #(.IMG_W(W), .IMG_H(H), .HBLANK(HB), .VBLANK(VB), .ADDR_W(AW), .RD_LAT(LAT)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .frame_done(fd_a), .bus(ia.master));
  pixel_stream_tx #(.IMG_W(W), .IMG_H(H), .HBLANK(0), .VBLANK(VB), .ADDR_W(AW), .RD_LAT(LAT)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .frame_done(fd_b), .bus(ib.master));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (ia.mem_rd) ia.mem_data <= mem[ia.mem_addr];
    if (ib.mem_rd) ib.mem_data <= mem[ib.mem_addr];
  end

  always @(negedge clk) begin
    if (ia.data_out_en) pq_a.push_back({32'(cyc), ia.data_out, ia.sof, ia.eol});
    else if (ia.sof || ia.eol) stray_a++;
    if (ib.data_out_en) pq_b.push_back({32'(cyc), ib.data_out, ib.sof, ib.eol});
    else if (ib.sof || ib.eol) stray_b++;
    if (ia.mem_rd) rq_a.push_back({32'(cyc), ia.mem_addr});
    if (ib.mem_rd) rq_b.push_back({32'(cyc), ib.mem_addr});
    if (fd_a) fq_a.push_back(cyc);
    if (fd_b) fq_b.push_back(cyc);
    if (cyc < 4096) busy_h[cyc] = busy_a;
  end

  // Reference raster model: pixel i of a frame whose first read happens at cycle t0.
  function automatic pix_t exp_pix(int hb, int t0, int i);
    int x = i % W;
    int y = i / W;
    logic [7:0] d = PAT ? 8'(x + y) : mem[y * W + x];
    return {32'(t0 + y * (W + hb) + x + LAT + 1), d, 1'(i == 0), 1'(x == W - 1)};
  endfunction

  function automatic rd_t exp_rd(int hb, int t0, int i);
    return {32'(t0 + (i / W) * (W + hb) + i % W), 8'(i)};
  endfunction

  function automatic int exp_fd(int hb, int t0);
    return t0 + NPIX + (H - 1) * hb + VB - 1;
  endfunction

  function automatic string ps(pix_t p);
    return $sformatf("cyc=%0d data=%0d sof=%b eol=%b", p[41:10], p[9:2], p[1], p[0]);
  endfunction

  function automatic string rs(rd_t r);
    return $sformatf("cyc=%0d addr=%0d", r[39:8], r[7:0]);
  endfunction

  task automatic clear_q();
    pq_a.delete(); pq_b.delete(); rq_a.delete(); rq_b.delete();
    fq_a.delete(); fq_b.delete(); stray_a = 0; stray_b = 0;
  endtask

  task automatic pulse_start_a(output int t0);
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; start_a = 1'b0; t0 = cyc;
  endtask

  task automatic wait_fd_a(input int n);
    for (int k = 0; k < 600 && fq_a.size() < n; k++) @(negedge clk);
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy_a, fd_a, ia.mem_rd, ia.data_out_en, ia.sof, ia.eol} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl_a: got %b, expected 000000", {busy_a, fd_a, ia.mem_rd, ia.data_out_en, ia.sof, ia.eol});
    end
    checks++;
    if (ia.data_out !== 8'd0 || ia.mem_addr !== 8'd0) begin
      errors++; $display("FAIL reset_bus_a: got data=%0d addr=%0d, expected 0 0", ia.data_out, ia.mem_addr);
    end
    checks++;
    if ({busy_b, fd_b, ib.mem_rd, ib.data_out_en, ib.sof, ib.eol, ib.data_out, ib.mem_addr} !== '0) begin
      errors++; $display("FAIL reset_b: got nonzero outputs, expected all 0");
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_frame();
    int t0, fd, nb;
    for (int f = 0; f < 3; f++) begin
      foreach (mem[k]) mem[k] = 8'($urandom);
      clear_q();
      repeat ($urandom_range(0, 4)) @(negedge clk);
      pulse_start_a(t0);
      wait_fd_a(1);
      fd = exp_fd(HB, t0);
      checks++;
      if (fq_a.size() != 1 || fq_a[0] != fd) begin
        errors++; $display("FAIL frame_done f%0d: got %0d pulses first=%0d, expected 1 at %0d",
                           f, fq_a.size(), (fq_a.size() > 0) ? fq_a[0] : -1, fd);
      end
      checks++;
      if (pq_a.size() != NPIX) begin
        errors++; $display("FAIL pix_count f%0d: got %0d, expected %0d", f, pq_a.size(), NPIX);
      end
      for (int i = 0; i < NPIX && i < pq_a.size(); i++) begin
        checks++;
        if (pq_a[i] !== exp_pix(HB, t0, i)) begin
          errors++; $display("FAIL pixel f%0d #%0d: got %s, expected %s", f, i, ps(pq_a[i]), ps(exp_pix(HB, t0, i)));
        end
      end
      checks++;
      if (rq_a.size() != (PAT ? 0 : NPIX)) begin
        errors++; $display("FAIL rd_count f%0d: got %0d, expected %0d", f, rq_a.size(), PAT ? 0 : NPIX);
      end
      for (int i = 0; i < NPIX && i < rq_a.size(); i++) begin
        checks++;
        if (rq_a[i] !== exp_rd(HB, t0, i)) begin
          errors++; $display("FAIL mem_rd f%0d #%0d: got %s, expected %s", f, i, rs(rq_a[i]), rs(exp_rd(HB, t0, i)));
        end
      end
      nb = 0;
      for (int c = t0; c <= fd; c++) nb += int'(busy_h[c]);
      checks++;
      if (nb != fd - t0 + 1 || busy_h[t0 - 1] !== 1'b0 || busy_h[fd + 1] !== 1'b0) begin
        errors++; $display("FAIL busy f%0d: got %0d high cycles pre=%b post=%b, expected %0d pre=0 post=0",
                           f, nb, busy_h[t0 - 1], busy_h[fd + 1], fd - t0 + 1);
      end
      checks++;
      if (stray_a != 0) begin
        errors++; $display("FAIL stray_marker f%0d: got %0d, expected 0", f, stray_a);
      end
    end
  endtask

  task automatic test_start_ignored();
    int t0;
    clear_q();
    pulse_start_a(t0);
    while (cyc < t0 + W + HB + 1) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    wait_fd_a(1);
    repeat (10) @(negedge clk);
    checks++;
    if (fq_a.size() != 1 || pq_a.size() != NPIX) begin
      errors++; $display("FAIL ignored_start: got %0d done %0d pixels, expected 1 done %0d pixels", fq_a.size(), pq_a.size(), NPIX);
    end
    for (int i = 0; i < NPIX && i < pq_a.size(); i++) begin
      checks++;
      if (pq_a[i] !== exp_pix(HB, t0, i)) begin
        errors++; $display("FAIL ignored_pixel #%0d: got %s, expected %s", i, ps(pq_a[i]), ps(exp_pix(HB, t0, i)));
      end
    end
  endtask

  task automatic test_back_to_back();
    int t0a, t0b;
    foreach (mem[k]) mem[k] = 8'($urandom);
    clear_q();
    @(negedge clk); start_a = 1'b1;
    @(posedge clk); #1; t0a = cyc;
    t0b = exp_fd(HB, t0a) + 1;
    while (cyc < t0b + 1) @(negedge clk);
    start_a = 1'b0;
    wait_fd_a(2);
    checks++;
    if (fq_a.size() != 2 || fq_a[0] != t0b - 1 || fq_a[1] != exp_fd(HB, t0b)) begin
      errors++; $display("FAIL b2b_done: got %0d pulses, expected 2 at %0d and %0d", fq_a.size(), t0b - 1, exp_fd(HB, t0b));
    end
    checks++;
    if (pq_a.size() != 2 * NPIX || rq_a.size() != (PAT ? 0 : 2 * NPIX)) begin
      errors++; $display("FAIL b2b_count: got pix=%0d rd=%0d, expected pix=%0d rd=%0d",
                         pq_a.size(), rq_a.size(), 2 * NPIX, PAT ? 0 : 2 * NPIX);
    end
    for (int i = 0; i < 2 * NPIX && i < pq_a.size(); i++) begin
      checks++;
      if (pq_a[i] !== exp_pix(HB, (i < NPIX) ? t0a : t0b, i % NPIX)) begin
        errors++; $display("FAIL b2b_pixel #%0d: got %s, expected %s", i, ps(pq_a[i]), ps(exp_pix(HB, (i < NPIX) ? t0a : t0b, i % NPIX)));
      end
    end
    for (int i = 0; i < 2 * NPIX && i < rq_a.size(); i++) begin
      checks++;
      if (rq_a[i] !== exp_rd(HB, (i < NPIX) ? t0a : t0b, i % NPIX)) begin
        errors++; $display("FAIL b2b_rd #%0d: got %s, expected %s", i, rs(rq_a[i]), rs(exp_rd(HB, (i < NPIX) ? t0a : t0b, i % NPIX)));
      end
    end
    checks++;
    if (busy_h[t0b - 1] !== 1'b1 || busy_h[t0b] !== 1'b1) begin
      errors++; $display("FAIL b2b_busy: got %b%b, expected 11", busy_h[t0b - 1], busy_h[t0b]);
    end
  endtask

  task automatic test_reset_mid();
    int t0;
    clear_q();
    pulse_start_a(t0);
    while (cyc < t0 + W + HB) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy_a, fd_a, ia.mem_rd, ia.data_out_en, ia.sof, ia.eol} !== 6'b0 || ia.data_out !== 8'd0 || ia.mem_addr !== 8'd0) begin
      errors++; $display("FAIL midreset_outputs: got ctrl=%b data=%0d addr=%0d, expected all 0",
                         {busy_a, fd_a, ia.mem_rd, ia.data_out_en, ia.sof, ia.eol}, ia.data_out, ia.mem_addr);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    repeat (15) @(negedge clk);
    checks++;
    if (pq_a.size() != 0 || rq_a.size() != 0 || fq_a.size() != 0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL midreset_quiet: got pix=%0d rd=%0d done=%0d busy=%b, expected 0 0 0 0",
                         pq_a.size(), rq_a.size(), fq_a.size(), busy_a);
    end
    foreach (mem[k]) mem[k] = 8'($urandom);
    pulse_start_a(t0);
    wait_fd_a(1);
    checks++;
    if (pq_a.size() != NPIX || fq_a.size() != 1) begin
      errors++; $display("FAIL midreset_restart: got %0d pixels %0d done, expected %0d 1", pq_a.size(), fq_a.size(), NPIX);
    end
    for (int i = 0; i < NPIX && i < pq_a.size(); i++) begin
      checks++;
      if (pq_a[i] !== exp_pix(HB, t0, i)) begin
        errors++; $display("FAIL restart_pixel #%0d: got %s, expected %s", i, ps(pq_a[i]), ps(exp_pix(HB, t0, i)));
      end
    end
  endtask

  task automatic test_hblank0();
    int t0;
    foreach (mem[k]) mem[k] = 8'($urandom);
    clear_q();
    @(negedge clk); start_b = 1'b1;
    @(posedge clk); #1; start_b = 1'b0; t0 = cyc;
    for (int k = 0; k < 600 && fq_b.size() < 1; k++) @(negedge clk);
    repeat (4) @(negedge clk);
    checks++;
    if (fq_b.size() != 1 || fq_b[0] != exp_fd(0, t0)) begin
      errors++; $display("FAIL hb0_done: got %0d pulses first=%0d, expected 1 at %0d",
                         fq_b.size(), (fq_b.size() > 0) ? fq_b[0] : -1, exp_fd(0, t0));
    end
    checks++;
    if (pq_b.size() != NPIX || rq_b.size() != (PAT ? 0 : NPIX) || stray_b != 0) begin
      errors++; $display("FAIL hb0_count: got pix=%0d rd=%0d stray=%0d, expected %0d %0d 0",
                         pq_b.size(), rq_b.size(), stray_b, NPIX, PAT ? 0 : NPIX);
    end
    for (int i = 0; i < NPIX && i < pq_b.size(); i++) begin
      checks++;
      if (pq_b[i] !== exp_pix(0, t0, i)) begin
        errors++; $display("FAIL hb0_pixel #%0d: got %s, expected %s", i, ps(pq_b[i]), ps(exp_pix(0, t0, i)));
      end
    end
    for (int i = 0; i < NPIX && i < rq_b.size(); i++) begin
      checks++;
      if (rq_b[i] !== exp_rd(0, t0, i)) begin
        errors++; $display("FAIL hb0_rd #%0d: got %s, expected %s", i, rs(rq_b[i]), rs(exp_rd(0, t0, i)));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (mem[k]) mem[k] = 8'($urandom);
    test_reset();
    test_frame();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_hblank0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
